led_pattern_gen: RTL and testbench

Multi-channel LED pattern generator and parametrised successor to the single-output blinker. A shared free-running prescaler derives a slow tick from the board clock. Each of NUM_CH channels is independently programmed through a simple write port to one of four modes: OFF, ON, BLINK or ONESHOT. It sits between board-level status logic and the user LEDs.

---
 rtl/led_pattern_gen.sv | 116 +++++++++++
 tb/tb_led_pattern_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: a shared prescaler tick drives per-channel
// OFF / ON / BLINK / ONESHOT patterns programmed through a single write port.
//
// mode     | meaning
// ---------+--------------------------------------------------------------
// OFF      | led held 0, counter frozen
// ON       | led held 1, counter frozen
// BLINK    | led toggles every hp_eff ticks (first rise after hp_eff ticks)
// ONESHOT  | led 1 for hp_eff ticks, then done pulse and fall back to OFF
module led_pattern_gen #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int TICK_HZ     = 1000,
  parameter int NUM_CH      = 8,
  parameter int PERIOD_W    = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_half_period,
  output logic [NUM_CH-1:0]   led,
  output logic [NUM_CH-1:0]   done,
  output logic                tick
);

  localparam int DIV_RAW = (TICK_HZ > 0) ? (CLK_FREQ_HZ / TICK_HZ) : 1;
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int PS_W    = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_t;

  logic [PS_W-1:0]     presc;
  logic [NUM_CH-1:0]   wr_sel;
  mode_t               mode [NUM_CH];
  logic [PERIOD_W-1:0] hp   [NUM_CH];
  logic [PERIOD_W-1:0] cnt  [NUM_CH];

  // Last count value before a toggle/expiry; a half-period of 0 behaves as 1.
  function automatic logic [PERIOD_W-1:0] last_cnt(input logic [PERIOD_W-1:0] h);
    return (h == '0) ? '0 : h - PERIOD_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= (presc == PS_W'(DIV - 1));
      if (presc == PS_W'(DIV - 1)) presc <= '0;
      else                         presc <= presc + PS_W'(1);
    end
  end

  always_comb begin
    wr_sel = '0;
    if (cfg_we && (int'(cfg_ch) < NUM_CH)) wr_sel[cfg_ch] = 1'b1;
  end

  // A write to a channel takes priority over a tick arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mode[i] <= MODE_OFF;
        hp[i]   <= '0;
        cnt[i]  <= '0;
      end
      led  <= '0;
      done <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        done[i] <= 1'b0;
        if (wr_sel[i]) begin
          mode[i] <= mode_t'(cfg_mode);
          hp[i]   <= cfg_half_period;
          cnt[i]  <= '0;
          led[i]  <= cfg_mode[0];
        end else begin
          case (mode[i])
            MODE_OFF: led[i] <= 1'b0;
            MODE_ON:  led[i] <= 1'b1;
            MODE_BLINK: begin
              if (tick) begin
                if (cnt[i] == last_cnt(hp[i])) begin
                  cnt[i] <= '0;
                  led[i] <= ~led[i];
                end else begin
                  cnt[i] <= cnt[i] + PERIOD_W'(1);
                end
              end
            end
            MODE_ONESHOT: begin
              if (tick) begin
                if (cnt[i] == last_cnt(hp[i])) begin
                  cnt[i]  <= '0;
                  led[i]  <= 1'b0;
                  mode[i] <= MODE_OFF;
                  done[i] <= 1'b1;
                end else begin
                  cnt[i] <= cnt[i] + PERIOD_W'(1);
                end
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: a tick-count reference model queues the
// expected {tick, done, led} for every cycle and a monitor compares at negedge.
module tb_led_pattern_gen;
  localparam int NC   = 5;
  localparam int DIV  = 10;
  localparam int PW   = 16;
  localparam int CH_W = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [CH_W-1:0] cfg_ch = '0;
  logic [1:0]    cfg_mode = '0;
  logic [PW-1:0] cfg_half_period = '0;
  logic [NC-1:0] led, done;
  logic          tick;

  led_pattern_gen #(
    .CLK_FREQ_HZ(100), .TICK_HZ(10), .NUM_CH(NC), .PERIOD_W(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_half_period(cfg_half_period),
    .led(led), .done(done), .tick(tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: per channel, mode and number of ticks counted since the write.
  int m_mode [NC] = '{default: 0};
  int m_hp   [NC] = '{default: 1};
  int m_k    [NC] = '{default: 0};
  int edges = 0;
  logic [NC-1:0] m_led, m_done;
  logic [2*NC:0] exp_q [$];

  always @(posedge clk) begin
    if (rst_n) begin
      bit tick_prev;
      tick_prev = (edges >= 1) && (edges % DIV == 0);
      edges++;
      m_done = '0;
      for (int c = 0; c < NC; c++) begin
        if (cfg_we && int'(cfg_ch) == c) begin
          m_mode[c] = int'(cfg_mode);
          m_hp[c]   = (cfg_half_period == 0) ? 1 : int'(cfg_half_period);
          m_k[c]    = 0;
        end else if (tick_prev && m_mode[c] >= 2) begin
          m_k[c]++;
          if (m_mode[c] == 3 && m_k[c] == m_hp[c]) begin
            m_mode[c] = 0;
            m_done[c] = 1'b1;
          end
        end
        case (m_mode[c])
          1:       m_led[c] = 1'b1;
          2:       m_led[c] = ((m_k[c] / m_hp[c]) % 2) == 1;
          3:       m_led[c] = 1'b1;
          default: m_led[c] = 1'b0;
        endcase
      end
      exp_q.push_back({(edges % DIV == 0), m_done, m_led});
    end
  end

  always @(negedge rst_n) begin
    edges = 0;
    for (int c = 0; c < NC; c++) begin
      m_mode[c] = 0;
      m_hp[c]   = 1;
      m_k[c]    = 0;
    end
    exp_q.delete();
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic [2*NC:0] exp_v, act_v;
      n_cmp++;
      act_v = {tick, done, led};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty t=%0t got tick=%b done=%b led=%b", $time, tick, done, led);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL scoreboard t=%0t got tick=%b done=%b led=%b expected tick=%b done=%b led=%b",
                   $time, act_v[2*NC], act_v[2*NC-1:NC], act_v[NC-1:0],
                   exp_v[2*NC], exp_v[2*NC-1:NC], exp_v[NC-1:0]);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; leaves the strobe asserted for exactly one posedge.
  task automatic wr(input int ch, input int mode, input int hp);
    cfg_we          = 1'b1;
    cfg_ch          = CH_W'(ch);
    cfg_mode        = 2'(mode);
    cfg_half_period = PW'(hp);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      if (tick) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_tick got no tick within %0d cycles, required one", 4 * DIV);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_cmp++;
    if ({tick, done, led} !== '0) begin
      n_fail++;
      $display("FAIL %s got tick=%b done=%b led=%b required all 0", name, tick, done, led);
    end
  endtask

  initial begin
    idle(3);
    #2 rst_n = 1'b1;
    idle(25);

    wr(0, 2, 3);
    idle(100);

    wr(1, 3, 2);
    idle(40);

    wr(2, 3, 5);
    wait_tick();
    wait_tick();
    idle(1);
    wr(2, 1, 0);
    idle(30);
    wr(2, 0, 0);
    idle(5);

    wr(5, 2, 7);
    wait_tick();
    wr(0, 2, 0);
    idle(60);

    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 3) == 0) wait_tick();
      wr(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
      idle(int'($urandom_range(0, 30)));
    end

    wr(0, 2, 1);
    wr(1, 3, 20);
    wr(3, 1, 0);
    idle(25);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset_immediate");
    idle(3);
    check_reset_outputs("reset_held");
    #2 rst_n = 1'b1;
    idle(45);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
